// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for reset_sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT    = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam logic [2:0] CAUSE_POR = 3'd0;
  localparam logic [2:0] CAUSE_PIN = 3'd1;
  localparam logic [2:0] CAUSE_PLL = 3'd2;
  localparam logic [2:0] CAUSE_SW  = 3'd3;
  localparam logic [2:0] CAUSE_WDT = 3'd4;

  // Cause priority when several sources hit on the same edge:
  // pin > PLL > software > watchdog. Only called when some source is active.
  function automatic logic [2:0] pick_cause(input logic pin_bad,
                                            input logic pll_bad,
                                            input logic sw_req);
    if (pin_bad)      return CAUSE_PIN;
    else if (pll_bad) return CAUSE_PLL;
    else if (sw_req)  return CAUSE_SW;
    else              return CAUSE_WDT;
  endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Synchroniser plus debounce counter for an asynchronous level input.
// The debounced level flips only after the synchronised level has
// disagreed with it for DEBOUNCE_CYCLES+1 consecutive edges (the counter
// must reach DEBOUNCE_CYCLES, then the flip happens on the following edge).
module reset_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic deb_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   deb_q, deb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign deb_o  = deb_q;

  // Multi-flop synchroniser chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  // Count disagreeing samples; flip the debounced level once the count is full.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_o != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: debounced pin, PLL lock and software request are
// combined, reset is stretched, then domain resets are released in order.
// Optional watchdog reset source: define RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_DOMAINS       = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STRETCH_CYCLES  = 64,
  parameter int unsigned STAGGER_CYCLES  = 8
`ifdef RESET_SEQ_WATCHDOG_EN
  ,
  parameter int unsigned WDT_CYCLES      = 1048576
`endif
) (
  input  logic                 i_brd_clk,
  input  logic                 i_brd_rst,
  input  logic                 i_reset_n,
  input  logic                 i_pll_locked,
  input  logic                 i_sw_rst,
`ifdef RESET_SEQ_WATCHDOG_EN
  input  logic                 i_wdt_kick,
`endif
  output logic [N_DOMAINS-1:0] o_rst,
  output logic                 o_ready,
  output logic [2:0]           o_cause,
  output logic [2:0]           o_monitor
);

  localparam int unsigned STR_W = $clog2(STRETCH_CYCLES + 1);
  localparam int unsigned STG_W = $clog2(STAGGER_CYCLES + 1);
  localparam int unsigned IDX_W = $clog2(N_DOMAINS + 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ALL  = IDX_W'(N_DOMAINS);

  state_e                 state_q, state_d;
  logic [N_DOMAINS-1:0]   rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [2:0]             cause_q, cause_d;
  logic [STR_W-1:0]       str_q, str_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic                   pin_sync, pin_deb;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_sync;
  logic                   pin_bad, pll_bad, wdt_fire, any_src;

  reset_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pin_deb (
    .clk_i  (i_brd_clk),
    .rst_i  (i_brd_rst),
    .async_i(i_reset_n),
    .sync_o (pin_sync),
    .deb_o  (pin_deb)
  );

  // PLL lock is only synchronised; no debounce.
  always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
    if (i_brd_rst) lock_sync_q <= '0;
    else           lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], i_pll_locked};
  end

  assign lock_sync = lock_sync_q[SYNC_STAGES-1];
  assign pin_bad   = ~pin_deb;
  assign pll_bad   = ~lock_sync;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  assign wdt_fire = (state_q == RUN) && (wdt_q == WDT_MAX);

  // Watchdog counts only while staying in RUN; a kick clears it.
  always_comb begin
    wdt_d = '0;
    if (state_q == RUN && state_d == RUN && !i_wdt_kick) wdt_d = wdt_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
    if (i_brd_rst) wdt_q <= '0;
    else           wdt_q <= wdt_d;
  end
`else
  assign wdt_fire = 1'b0;
`endif

  assign any_src = pin_bad | pll_bad | i_sw_rst | wdt_fire;

  // Sequencer next-state: qualify sources, stretch, staggered release.
  always_comb begin
    state_d = state_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    str_d   = str_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    case (state_q)
      ASSERT: begin
        rst_d   = '1;
        ready_d = 1'b0;
        str_d   = '0;
        stg_d   = '0;
        idx_d   = '0;
        if (pin_deb && !i_sw_rst) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Missing lock is the normal wait condition here, not a reset source.
        if (pin_bad || i_sw_rst) begin
          state_d = ASSERT;
          cause_d = pin_bad ? CAUSE_PIN : CAUSE_SW;
        end else if (lock_sync) begin
          state_d = STRETCH;
          str_d   = '0;
        end
      end
      STRETCH, RELEASE, RUN: begin
        if (any_src) begin
          state_d = ASSERT;
          rst_d   = '1;
          ready_d = 1'b0;
          str_d   = '0;
          stg_d   = '0;
          idx_d   = '0;
          cause_d = pick_cause(pin_bad, pll_bad, i_sw_rst);
        end else if (state_q == STRETCH) begin
          if (str_q == STR_LAST) begin
            // Domain 0 leaves reset on the same edge RELEASE is entered.
            state_d  = RELEASE;
            rst_d[0] = 1'b0;
            idx_d    = IDX_W'(1);
            stg_d    = '0;
          end else begin
            str_d = str_q + 1'b1;
          end
        end else if (state_q == RELEASE) begin
          if (idx_q == IDX_ALL) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else if (stg_q == STG_LAST) begin
            for (int unsigned k = 0; k < N_DOMAINS; k++) begin
              if (k == 32'(idx_q)) rst_d[k] = 1'b0;
            end
            idx_d = idx_q + 1'b1;
            stg_d = '0;
          end else begin
            stg_d = stg_q + 1'b1;
          end
        end
      end
      default: state_d = ASSERT;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge i_brd_clk or posedge i_brd_rst) begin
    if (i_brd_rst) begin
      state_q <= ASSERT;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
      str_q   <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
      str_q   <= str_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
    end
  end

  assign o_rst     = rst_q;
  assign o_ready   = ready_q;
  assign o_cause   = cause_q;
  assign o_monitor = {rst_q[0], pin_deb, pin_sync};

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default timing parameters.
// Cycle N means "sampled 1ns after the N-th rising edge following reset release".
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst, pin, lock, sw;
  logic [2:0] o_rst, cause, mon;
  logic       ready;
`ifdef RESET_SEQ_WATCHDOG_EN
  logic       kick = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_DOMAINS      (3),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .STRETCH_CYCLES (64),
    .STAGGER_CYCLES (8)
`ifdef RESET_SEQ_WATCHDOG_EN
    ,
    .WDT_CYCLES     (100)
`endif
  ) dut (
    .i_brd_clk   (clk),
    .i_brd_rst   (rst),
    .i_reset_n   (pin),
    .i_pll_locked(lock),
    .i_sw_rst    (sw),
`ifdef RESET_SEQ_WATCHDOG_EN
    .i_wdt_kick  (kick),
`endif
    .o_rst       (o_rst),
    .o_ready     (ready),
    .o_cause     (cause),
    .o_monitor   (mon)
  );

  typedef struct {
    int         cyc;
    logic       pin;
    logic       lock;
    logic       sw;
    logic [2:0] rst;
    logic       rdy;
    logic [2:0] cause;
    logic [2:0] mon;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic upto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int glitch;
    int x, y, z;

    // Power-on sequence: pin and lock high from the start.
    vecs[0]  = '{0,   1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0, 3'b100};
    vecs[1]  = '{1,   1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0, 3'b101};
    vecs[2]  = '{17,  1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0, 3'b101};
    vecs[3]  = '{18,  1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0, 3'b111};
    vecs[4]  = '{20,  1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0, 3'b111};
    vecs[5]  = '{83,  1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd0, 3'b111};
    vecs[6]  = '{84,  1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 3'd0, 3'b011};
    vecs[7]  = '{91,  1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 3'd0, 3'b011};
    vecs[8]  = '{92,  1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 3'd0, 3'b011};
    vecs[9]  = '{99,  1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 3'd0, 3'b011};
    vecs[10] = '{100, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'd0, 3'b011};
    vecs[11] = '{101, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 3'd0, 3'b011};

    rst = 1'b1; pin = 1'b1; lock = 1'b1; sw = 1'b0; cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rst",   o_rst, 3'b111);
    chk("reset_ready", ready, 1'b0);
    chk("reset_cause", cause, 3'd0);
    chk("reset_mon",   mon,   3'b100);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      pin = vecs[i].pin; lock = vecs[i].lock; sw = vecs[i].sw;
      upto(vecs[i].cyc);
      chk("por_rst",   o_rst, vecs[i].rst);
      chk("por_ready", ready, vecs[i].rdy);
      chk("por_cause", cause, vecs[i].cause);
      chk("por_mon",   mon,   vecs[i].mon);
    end

    // 10-cycle pin glitch in RUN must not reset anything.
    glitch = 0;
    upto(105);
    pin = 1'b0;
    repeat (10) begin
      tick();
      if (!ready || !mon[1]) glitch++;
    end
    pin = 1'b1;
    while (cyc < 150) begin
      tick();
      if (!ready || !mon[1]) glitch++;
    end
    chk("glitch_no_reset", glitch, 0);

    // 20-cycle pin low: debounced low 19 edges later, reset the edge after.
    x = 150;
    pin = 1'b0;
    upto(x + 18);
    chk("pin_deb_still_hi", mon[1], 1'b1);
    upto(x + 19);
    chk("pin_deb_lo",       mon[1], 1'b0);
    chk("pin_rst_not_yet",  o_rst,  3'b000);
    upto(x + 20);
    chk("pin_rst",   o_rst, 3'b111);
    chk("pin_ready", ready, 1'b0);
    chk("pin_cause", cause, 3'd1);
    pin = 1'b1;
    upto(x + 25);
    sw = 1'b1;
    tick();
    sw = 1'b0;
    chk("sw_in_assert_ignored", cause, 3'd1);
    upto(x + 105);
    chk("pin_rerelease_d0", o_rst, 3'b110);
    upto(x + 121);
    chk("pin_ready_not_yet", ready, 1'b0);
    upto(x + 122);
    chk("pin_ready_again", ready, 1'b1);
    chk("pin_rst_clear",   o_rst, 3'b000);

    // Software pulse in RUN, then PLL loss during the following RELEASE.
    y = 280;
    upto(y - 1);
    sw = 1'b1;
    tick();
    sw = 1'b0;
    chk("sw_rst",   o_rst, 3'b111);
    chk("sw_ready", ready, 1'b0);
    chk("sw_cause", cause, 3'd3);
    upto(y + 65);
    chk("sw_hold", o_rst, 3'b111);
    upto(y + 66);
    chk("sw_release_d0", o_rst, 3'b110);
    upto(y + 68);
    lock = 1'b0;
    upto(y + 70);
    chk("pll_not_yet", o_rst, 3'b110);
    upto(y + 71);
    chk("pll_rst",   o_rst, 3'b111);
    chk("pll_cause", cause, 3'd2);
    upto(y + 75);
    lock = 1'b1;
    upto(y + 158);
    chk("pll_ready_not_yet", ready, 1'b0);
    upto(y + 159);
    chk("pll_ready", ready, 1'b1);
    chk("pll_rst_clear", o_rst, 3'b000);
    chk("pll_cause_kept", cause, 3'd2);

    // Debounced pin low and software request on the same edge: pin wins.
    z = 449;
    upto(z);
    pin = 1'b0;
    upto(z + 19);
    chk("simul_deb_lo", mon[1], 1'b0);
    sw = 1'b1;
    tick();
    sw = 1'b0;
    pin = 1'b1;
    chk("simul_rst",   o_rst, 3'b111);
    chk("simul_cause", cause, 3'd1);
    upto(z + 107);
    chk("mid_release", o_rst, 3'b110);

    // Asynchronous board reset mid-RELEASE acts without a clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst",   o_rst, 3'b111);
    chk("async_ready", ready, 1'b0);
    chk("async_cause", cause, 3'd0);
    chk("async_mon",   mon,   3'b100);

`ifdef RESET_SEQ_WATCHDOG_EN
    begin
      int drops;
      int k;
      @(negedge clk);
      rst = 1'b0;
      cyc = -1;
      upto(101);
      chk("wdt_por_ready", ready, 1'b1);
      drops = 0;
      for (int n = 0; n < 300; n++) begin
        kick = (n % 50 == 49);
        tick();
        if (!ready) drops++;
      end
      kick = 1'b0;
      chk("wdt_kicked_no_reset", drops, 0);
      k = cyc;
      upto(k + 100);
      chk("wdt_not_yet", ready, 1'b1);
      upto(k + 101);
      chk("wdt_rst",   o_rst, 3'b111);
      chk("wdt_cause", cause, 3'd4);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
